window_read_sequencer: RTL and testbench

Read-side initiator for the image memory unit. After a `start` it walks every valid top-left position of a K×K sliding window over the IMAGE_WIDTH×IMAGE_HEIGHT image in row-major order. It drives `en`/`read`/`step`/per-unit addresses into the memory unit, spreading consecutive window positions across NUM_UNITS lanes. It honours downstream backpressure and counts the memory unit's `en_out` returns to signal completion.

---
 rtl/window_read_sequencer.sv | 166 ++++++++++++++++
 tb/tb_window_read_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/window_read_sequencer.sv
// Read-side sequencer: sweeps every KxK window top-left over the image, issuing NUM_UNITS positions per group.
// Optional macro SEQ_STALL_CNT_EN enables the saturating backpressure stall counter on stall_count.
module window_read_sequencer #(
  parameter int IMAGE_WIDTH  = 4,
  parameter int IMAGE_HEIGHT = 4,
  parameter int NUM_UNITS    = 2,
  localparam int AW = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT),
  localparam int KW = $clog2(IMAGE_WIDTH)+1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [KW-1:0]           kernel_dim_in,
  input  logic                    ready,
  input  logic                    en_out,
  output logic                    en,
  output logic                    read,
  output logic                    step,
  output logic [NUM_UNITS*AW-1:0] addres_out,
  output logic [NUM_UNITS-1:0]    lane_valid,
  output logic [KW-1:0]           kernel_dim,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [15:0]             stall_count
);

  localparam int CW = $clog2(IMAGE_WIDTH+1);
  localparam int RW = $clog2(IMAGE_HEIGHT+NUM_UNITS+1);
  localparam int GW = AW+1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t        state, state_n;
  logic [KW-1:0] k_q;
  logic [RW-1:0] base_row;
  logic [CW-1:0] base_col;
  logic [GW-1:0] grp_cnt, ret_cnt;
  logic          step_q, err_q;
  logic [CW-1:0] ow, ow_last;
  logic [RW-1:0] oh;
  logic          k_ok, start_ok, last_grp, ret_hit;

  // Index NUM_UNITS holds the position after the last lane, i.e. the next group's lane 0.
  logic [RW-1:0] lane_row [NUM_UNITS+1];
  logic [CW-1:0] lane_col [NUM_UNITS+1];

  assign ow      = CW'(IMAGE_WIDTH + 1 - int'(k_q));
  assign ow_last = ow - CW'(1);
  assign oh      = RW'(IMAGE_HEIGHT + 1 - int'(k_q));

  assign k_ok     = (kernel_dim_in != '0) && (int'(kernel_dim_in) <= IMAGE_WIDTH) &&
                    (int'(kernel_dim_in) <= IMAGE_HEIGHT);
  assign start_ok = (state == IDLE) && start && k_ok;

  always_comb begin
    lane_row[0] = base_row;
    lane_col[0] = base_col;
    for (int unsigned u = 1; u <= NUM_UNITS; u++) begin
      if (lane_col[u-1] == ow_last) begin
        lane_col[u] = '0;
        lane_row[u] = lane_row[u-1] + RW'(1);
      end else begin
        lane_col[u] = lane_col[u-1] + CW'(1);
        lane_row[u] = lane_row[u-1];
      end
    end
  end

  // Row-major order means a position is past the end exactly when its row is.
  always_comb begin
    addres_out = '0;
    lane_valid = '0;
    for (int unsigned u = 0; u < NUM_UNITS; u++) begin
      if ((state == ISSUE) && (lane_row[u] < oh)) begin
        lane_valid[u]          = 1'b1;
        addres_out[u*AW +: AW] = AW'(int'(lane_row[u]) * IMAGE_WIDTH + int'(lane_col[u]));
      end
    end
  end

  assign last_grp = lane_row[NUM_UNITS] >= oh;
  assign ret_hit  = (ret_cnt + GW'(en_out)) >= grp_cnt;

  always_comb begin
    state_n = state;
    en      = 1'b0;
    read    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: if (start_ok) state_n = ISSUE;
      ISSUE: begin
        en   = 1'b1;
        read = 1'b1;
        busy = 1'b1;
        if (ready && last_grp) state_n = DRAIN;
      end
      DRAIN: begin
        en   = 1'b1;
        busy = 1'b1;
        if (ret_hit) state_n = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      k_q      <= '0;
      base_row <= '0;
      base_col <= '0;
      grp_cnt  <= '0;
      ret_cnt  <= '0;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state  <= state_n;
      err_q  <= (state == IDLE) && start && !k_ok;
      step_q <= (state == ISSUE) && ready && !last_grp;
      if (start_ok) begin
        k_q      <= kernel_dim_in;
        base_row <= '0;
        base_col <= '0;
        grp_cnt  <= '0;
        ret_cnt  <= '0;
      end else begin
        if ((state == ISSUE) && ready) begin
          base_row <= lane_row[NUM_UNITS];
          base_col <= lane_col[NUM_UNITS];
          grp_cnt  <= grp_cnt + GW'(1);
        end
        if (((state == ISSUE) || (state == DRAIN)) && en_out)
          ret_cnt <= ret_cnt + GW'(1);
      end
    end
  end

  assign step       = step_q;
  assign err        = err_q;
  assign kernel_dim = (state == IDLE) ? '0 : k_q;

`ifdef SEQ_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_q <= '0;
    else if (start_ok)
      stall_q <= '0;
    else if ((state == ISSUE) && !ready && (stall_q != '1))
      stall_q <= stall_q + 16'd1;
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_window_read_sequencer.sv
// Directed self-checking bench for window_read_sequencer (4x4 image, 2 lanes).
module tb_window_read_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, ready, en_out;
  logic [2:0] kernel_dim_in;
  logic       en, read, step, busy, done, err;
  logic [7:0] addres_out;
  logic [1:0] lane_valid;
  logic [2:0] kernel_dim;
  logic [15:0] stall_count;

  int passed = 0;
  int failed = 0;
  int total  = 0;

`ifdef SEQ_STALL_CNT_EN
  localparam int EXP_STALL = 3;
`else
  localparam int EXP_STALL = 0;
`endif

  always #5 clk = ~clk;

  window_read_sequencer #(
    .IMAGE_WIDTH (4),
    .IMAGE_HEIGHT(4),
    .NUM_UNITS   (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .kernel_dim_in(kernel_dim_in),
    .ready        (ready),
    .en_out       (en_out),
    .en           (en),
    .read         (read),
    .step         (step),
    .addres_out   (addres_out),
    .lane_valid   (lane_valid),
    .kernel_dim   (kernel_dim),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .stall_count  (stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grp(input string tag, input int a0, input int a1, input int lv, input int st);
    chk({tag, ".a0"}, 32'(addres_out[3:0]), a0);
    chk({tag, ".a1"}, 32'(addres_out[7:4]), a1);
    chk({tag, ".lv"}, 32'(lane_valid), lv);
    chk({tag, ".step"}, 32'(step), st);
    chk({tag, ".read"}, 32'(read), 1);
  endtask

  task automatic chk_drain(input string tag);
    chk({tag, ".en"}, 32'(en), 1);
    chk({tag, ".read"}, 32'(read), 0);
    chk({tag, ".busy"}, 32'(busy), 1);
    chk({tag, ".done"}, 32'(done), 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".en"}, 32'(en), 0);
    chk({tag, ".read"}, 32'(read), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".addr"}, 32'(addres_out), 0);
    chk({tag, ".lv"}, 32'(lane_valid), 0);
  endtask

  task automatic start_sweep(input logic [2:0] k);
    kernel_dim_in = k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int k2_a0 [5] = '{0, 2, 5, 8, 10};
    int k2_a1 [5] = '{1, 4, 6, 9, 0};
    int k2_lv [5] = '{3, 3, 3, 3, 1};
    logic [2:0] bad_k [2] = '{3'd0, 3'd5};

    reset = 1'b1; start = 1'b0; ready = 1'b1; en_out = 1'b0; kernel_dim_in = '0;
    @(negedge clk);
    chk_idle("rst");
    chk("rst.step", 32'(step), 0);
    chk("rst.err", 32'(err), 0);
    chk("rst.kdim", 32'(kernel_dim), 0);
    chk("rst.stall", 32'(stall_count), 0);
    reset = 1'b0;
    @(negedge clk);

    // K=2: five groups, en_out once per group
    start_sweep(3'd2);
    chk("k2.kdim", 32'(kernel_dim), 2);
    for (int g = 0; g < 5; g++) begin
      chk_grp($sformatf("k2.g%0d", g), k2_a0[g], k2_a1[g], k2_lv[g], (g > 0) ? 1 : 0);
      en_out = 1'b1;
      @(negedge clk);
    end
    en_out = 1'b0;
    chk_drain("k2.drain");
    chk("k2.drain.lv", 32'(lane_valid), 0);
    @(negedge clk);
    chk("k2.done", 32'(done), 1);
    chk("k2.done.busy", 32'(busy), 1);
    @(negedge clk);
    chk_idle("k2.idle");

    // K=4: one group, only lane 0 valid
    start_sweep(3'd4);
    chk_grp("k4.g0", 0, 0, 1, 0);
    en_out = 1'b1;
    @(negedge clk);
    en_out = 1'b0;
    chk_drain("k4.drain");
    @(negedge clk);
    chk("k4.done", 32'(done), 1);
    @(negedge clk);
    chk_idle("k4.idle");

    // rejected kernel sizes
    for (int i = 0; i < 2; i++) begin
      start_sweep(bad_k[i]);
      chk($sformatf("bad%0d.err", bad_k[i]), 32'(err), 1);
      chk_idle($sformatf("bad%0d.c1", bad_k[i]));
      @(negedge clk);
      chk($sformatf("bad%0d.err_clr", bad_k[i]), 32'(err), 0);
      chk_idle($sformatf("bad%0d.c2", bad_k[i]));
    end

    // K=1: eight groups, three stall cycles on group 2
    start_sweep(3'd1);
    for (int g = 0; g < 8; g++) begin
      chk_grp($sformatf("k1.g%0d", g), 2*g, 2*g+1, 3, (g > 0) ? 1 : 0);
      if (g == 2) begin
        ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          if (s == 2) ready = 1'b1;
          chk_grp($sformatf("k1.hold%0d", s), 4, 5, 3, 0);
        end
      end
      en_out = 1'b1;
      @(negedge clk);
    end
    en_out = 1'b0;
    chk_drain("k1.drain");
    @(negedge clk);
    chk("k1.done", 32'(done), 1);
    chk("k1.stall", 32'(stall_count), EXP_STALL);
    @(negedge clk);
    chk_idle("k1.idle");
    chk("k1.stall_hold", 32'(stall_count), EXP_STALL);

    // reset during group 3, then restart; en_out withheld until DRAIN
    start_sweep(3'd2);
    repeat (3) @(negedge clk);
    chk_grp("rs.g3", 8, 9, 3, 1);
    #1 reset = 1'b1;
    #1;
    chk_idle("rs.async");
    chk("rs.async.step", 32'(step), 0);
    chk("rs.async.kdim", 32'(kernel_dim), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_sweep(3'd2);
    chk_grp("rs.g0", 0, 1, 3, 0);
    @(negedge clk);
    for (int g = 1; g < 5; g++) begin
      chk_grp($sformatf("rs.g%0d", g), k2_a0[g], k2_a1[g], k2_lv[g], 1);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      chk_drain($sformatf("wd.wait%0d", i));
      @(negedge clk);
    end
    en_out = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk_drain($sformatf("wd.ret%0d", i));
      @(negedge clk);
    end
    en_out = 1'b0;
    chk("wd.done", 32'(done), 1);
    @(negedge clk);
    chk_idle("wd.idle");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
